// File: rtl/fir_polyphase_tx.sv
// Multi-channel polyphase pulse-shaping FIR: one binary symbol per channel per baud in,
// OVER_SAMP truncated and saturated shaped samples per baud out, shared runtime-loadable taps.
module fir_polyphase_tx #(
    parameter int NB_COEFF  = 10,
    parameter int NBF_COEFF = 8,
    parameter int OVER_SAMP = 8,
    parameter int N_BAUDS   = 7,
    parameter int N_CH      = 2,
    parameter int NB_OUT    = 11,
    parameter int NBF_OUT   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_enable,
    input  logic                                  i_valid,
    input  logic [N_CH-1:0]                       i_symbols,
    input  logic                                  i_coef_we,
    input  logic [$clog2(OVER_SAMP*N_BAUDS)-1:0]  i_coef_addr,
    input  logic [NB_COEFF-1:0]                   i_coef_data,
    output logic [N_CH*NB_OUT-1:0]                o_data,
    output logic                                  o_valid,
    output logic [$clog2(OVER_SAMP)-1:0]          o_phase,
    output logic [N_CH-1:0]                       o_sat
);
    localparam int N_TAPS   = OVER_SAMP * N_BAUDS;
    localparam int NB_PHASE = $clog2(OVER_SAMP);
    localparam int NB_SUM   = NB_COEFF + $clog2(N_BAUDS) + 1;
    localparam int SHIFT    = NBF_COEFF - NBF_OUT;
    localparam logic signed [NB_SUM-1:0] OUT_MAX = NB_SUM'((2 ** (NB_OUT - 1)) - 1);
    localparam logic signed [NB_SUM-1:0] OUT_MIN = NB_SUM'(-(2 ** (NB_OUT - 1)));

    logic [N_BAUDS-1:0]         sr_q [N_CH];
    logic [NB_PHASE-1:0]        phase_q;
    logic [NB_PHASE-1:0]        phase_d;
    logic signed [NB_COEFF-1:0] coef_q [N_TAPS];
    logic [N_CH*NB_OUT-1:0]     data_q;
    logic [N_CH*NB_OUT-1:0]     data_d;
    logic                       valid_q;
    logic [NB_PHASE-1:0]        out_phase_q;
    logic [N_CH-1:0]            sat_q;
    logic [N_CH-1:0]            sat_d;

    // A new symbol restarts the polyphase sweep; otherwise the same symbols are re-filtered.
    always_comb begin
        phase_d = phase_q;
        if (i_enable && i_valid) begin
            phase_d = '0;
        end else if (i_enable) begin
            phase_d = (phase_q == NB_PHASE'(OVER_SAMP - 1)) ? '0 : phase_q + NB_PHASE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sr_q[c] <= '0;
            end
        end else if (i_enable) begin
            phase_q <= phase_d;
            if (i_valid) begin
                for (int c = 0; c < N_CH; c++) begin
                    sr_q[c] <= {sr_q[c][N_BAUDS-2:0], i_symbols[c]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_TAPS; t++) begin
                coef_q[t] <= '0;
            end
        end else if (i_coef_we && (int'(i_coef_addr) < N_TAPS)) begin
            coef_q[i_coef_addr] <= i_coef_data;
        end
    end

    // Taps are sign-extended before negation so the most negative coefficient cannot wrap.
    always_comb begin
        logic signed [NB_SUM-1:0] acc;
        logic signed [NB_SUM-1:0] tap;
        logic signed [NB_SUM-1:0] shifted;
        int                       idx;
        acc     = '0;
        tap     = '0;
        shifted = '0;
        idx     = 0;
        data_d  = '0;
        sat_d   = '0;
        for (int c = 0; c < N_CH; c++) begin
            acc = '0;
            for (int k = 0; k < N_BAUDS; k++) begin
                idx = k * OVER_SAMP + int'(phase_q);
                tap = NB_SUM'(coef_q[idx]);
                acc = sr_q[c][k] ? acc + tap : acc - tap;
            end
            shifted = acc >>> SHIFT;
            if (shifted > OUT_MAX) begin
                data_d[c*NB_OUT +: NB_OUT] = OUT_MAX[NB_OUT-1:0];
                sat_d[c]                   = 1'b1;
            end else if (shifted < OUT_MIN) begin
                data_d[c*NB_OUT +: NB_OUT] = OUT_MIN[NB_OUT-1:0];
                sat_d[c]                   = 1'b1;
            end else begin
                data_d[c*NB_OUT +: NB_OUT] = shifted[NB_OUT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            out_phase_q <= '0;
            sat_q       <= '0;
        end else if (i_enable) begin
            data_q      <= data_d;
            valid_q     <= 1'b1;
            out_phase_q <= phase_q;
            sat_q       <= sat_d;
        end else begin
            valid_q     <= 1'b0;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_phase = out_phase_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_fir_polyphase_tx.sv
// Self-checking bench for fir_polyphase_tx: directed scenarios with explicit expected values
// plus randomized traffic checked against an arithmetic model of the filter.
module tb_fir_polyphase_tx;
    localparam int NB_COEFF  = 10;
    localparam int NBF_COEFF = 8;
    localparam int OVER_SAMP = 8;
    localparam int N_BAUDS   = 7;
    localparam int N_CH      = 2;
    localparam int NB_OUT    = 11;
    localparam int NBF_OUT   = 8;
    localparam int N_TAPS    = OVER_SAMP * N_BAUDS;
    localparam int NB_ADDR   = $clog2(N_TAPS);
    localparam int NB_PHASE  = $clog2(OVER_SAMP);
    localparam int OUT_MAX   = (2 ** (NB_OUT - 1)) - 1;
    localparam int OUT_MIN   = -(2 ** (NB_OUT - 1));

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     i_enable = 1'b0;
    logic                     i_valid = 1'b0;
    logic [N_CH-1:0]          i_symbols = '0;
    logic                     i_coef_we = 1'b0;
    logic [NB_ADDR-1:0]       i_coef_addr = '0;
    logic [NB_COEFF-1:0]      i_coef_data = '0;
    logic [N_CH*NB_OUT-1:0]   o_data;
    logic                     o_valid;
    logic [NB_PHASE-1:0]      o_phase;
    logic [N_CH-1:0]          o_sat;

    int checks = 0;
    int failures = 0;

    int                       m_coef [N_TAPS];
    int                       m_hist [N_CH][N_BAUDS];
    int                       m_phase;
    logic [N_CH*NB_OUT-1:0]   exp_data;
    logic                     exp_valid;
    logic [NB_PHASE-1:0]      exp_phase;
    logic [N_CH-1:0]          exp_sat;

    fir_polyphase_tx #(
        .NB_COEFF(NB_COEFF), .NBF_COEFF(NBF_COEFF), .OVER_SAMP(OVER_SAMP),
        .N_BAUDS(N_BAUDS), .N_CH(N_CH), .NB_OUT(NB_OUT), .NBF_OUT(NBF_OUT)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
        .i_symbols(i_symbols), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
        .i_coef_data(i_coef_data), .o_data(o_data), .o_valid(o_valid),
        .o_phase(o_phase), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    // Filter output for one channel straight from the symbol history (+1/-1) and tap table.
    function automatic int ref_sample(input int c, output bit clipped);
        int s;
        s = 0;
        for (int k = 0; k < N_BAUDS; k++) begin
            s += (m_hist[c][k] != 0 ? 1 : -1) * m_coef[k*OVER_SAMP + m_phase];
        end
        s = s >>> (NBF_COEFF - NBF_OUT);
        clipped = (s > OUT_MAX) || (s < OUT_MIN);
        if (s > OUT_MAX) s = OUT_MAX;
        if (s < OUT_MIN) s = OUT_MIN;
        return s;
    endfunction

    // Drives one clock cycle of inputs and advances the model across that edge.
    task automatic step(input logic rs, input logic en, input logic vld, input logic [N_CH-1:0] sym,
                        input logic we, input int addr, input int cdata);
        int          v;
        bit          clip;
        logic [31:0] raw;
        rst = rs;
        i_enable = en;
        i_valid = vld;
        i_symbols = sym;
        i_coef_we = we;
        raw = addr;
        i_coef_addr = raw[NB_ADDR-1:0];
        raw = cdata;
        i_coef_data = raw[NB_COEFF-1:0];
        @(posedge clk);
        if (rs) begin
            for (int t = 0; t < N_TAPS; t++) m_coef[t] = 0;
            for (int c = 0; c < N_CH; c++)
                for (int k = 0; k < N_BAUDS; k++) m_hist[c][k] = 0;
            m_phase = 0;
            exp_data = '0;
            exp_valid = 1'b0;
            exp_phase = '0;
            exp_sat = '0;
        end else begin
            if (en) begin
                for (int c = 0; c < N_CH; c++) begin
                    v = ref_sample(c, clip);
                    exp_data[c*NB_OUT +: NB_OUT] = v[NB_OUT-1:0];
                    exp_sat[c] = clip;
                end
                exp_phase = m_phase[NB_PHASE-1:0];
                exp_valid = 1'b1;
                if (vld) begin
                    for (int c = 0; c < N_CH; c++) begin
                        for (int k = N_BAUDS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                        m_hist[c][0] = int'(sym[c]);
                    end
                    m_phase = 0;
                end else begin
                    m_phase = (m_phase + 1) % OVER_SAMP;
                end
            end else begin
                exp_valid = 1'b0;
            end
            if (we && addr >= 0 && addr < N_TAPS) m_coef[addr] = cdata;
        end
        #1;
    endtask

    task automatic load_all(input int val);
        for (int t = 0; t < N_TAPS; t++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, t, val);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
        checks++;
        if (o_data !== '0 || o_valid !== 1'b0 || o_phase !== '0 || o_sat !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: data=%h valid=%b phase=%0d sat=%b required all zero",
                     o_data, o_valid, o_phase, o_sat);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, ($urandom_range(0, 3) == 0), 2'($urandom), 1'b0, 0, 0);
            checks++;
            if (o_data !== '0 || o_valid !== 1'b1 || o_sat !== '0) begin
                failures++;
                $display("[TB] FAIL zero_coef_output: data=%h valid=%b sat=%b required data=0 valid=1 sat=0",
                         o_data, o_valid, o_sat);
            end
        end
    endtask

    task automatic test_flat_taps();
        logic [N_CH-1:0]   sym;
        logic [NB_OUT-1:0] e0, e1;
        int                v1;
        load_all(64);
        for (int pass = 0; pass < 2; pass++) begin
            sym = (pass == 0) ? 2'b11 : 2'b01;
            v1  = (pass == 0) ? 448 : -448;
            e0  = NB_OUT'(448);
            e1  = v1[NB_OUT-1:0];
            for (int b = 0; b < N_BAUDS; b++) begin
                for (int p = 0; p < OVER_SAMP; p++) begin
                    step(1'b0, 1'b1, (p == 0), sym, 1'b0, 0, 0);
                    checks++;
                    if (o_data !== exp_data || o_valid !== exp_valid || o_phase !== exp_phase || o_sat !== exp_sat) begin
                        failures++;
                        $display("[TB] FAIL flat_model: got data=%h valid=%b phase=%0d sat=%b want data=%h valid=%b phase=%0d sat=%b",
                                 o_data, o_valid, o_phase, o_sat, exp_data, exp_valid, exp_phase, exp_sat);
                    end
                    if (b == N_BAUDS - 1 && p > 0) begin
                        checks++;
                        if (o_data !== {e1, e0} || o_sat !== '0) begin
                            failures++;
                            $display("[TB] FAIL flat_value sym=%b: got data=%h sat=%b want data=%h sat=0",
                                     sym, o_data, o_sat, {e1, e0});
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_latency_phase();
        logic [NB_OUT-1:0] want;
        for (int t = 0; t < N_TAPS; t++) step(1'b0, 1'b1, 1'b0, '0, 1'b1, t, (t < OVER_SAMP) ? t + 1 : 0);
        step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
        for (int i = 0; i < 2 * OVER_SAMP; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 0);
            want = NB_OUT'(i % OVER_SAMP + 1);
            checks++;
            if (o_data !== {want, want} || o_phase !== NB_PHASE'(i % OVER_SAMP) || o_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL latency_phase i=%0d: got data=%h phase=%0d valid=%b want data=%h phase=%0d valid=1",
                         i, o_data, o_phase, o_valid, {want, want}, i % OVER_SAMP);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [NB_OUT-1:0] frz;
        logic [NB_OUT-1:0] nxt;
        frz = NB_OUT'(3);
        nxt = NB_OUT'(4);
        step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, (i == 2), 2'b00, 1'b0, 0, 0);
            checks++;
            if (o_valid !== 1'b0 || o_data !== {frz, frz} || o_phase !== NB_PHASE'(2)) begin
                failures++;
                $display("[TB] FAIL enable_freeze i=%0d: got valid=%b data=%h phase=%0d want valid=0 data=%h phase=2",
                         i, o_valid, o_data, o_phase, {frz, frz});
            end
        end
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 0);
        checks++;
        if (o_valid !== 1'b1 || o_data !== {nxt, nxt} || o_phase !== NB_PHASE'(3)) begin
            failures++;
            $display("[TB] FAIL enable_resume: got valid=%b data=%h phase=%0d want valid=1 data=%h phase=3",
                     o_valid, o_data, o_phase, {nxt, nxt});
        end
    endtask

    task automatic test_coef_hazard();
        logic [NB_OUT-1:0] old0;
        logic [NB_OUT-1:0] new0;
        old0 = NB_OUT'(1);
        new0 = NB_OUT'(100);
        step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, 0, 100);
        checks++;
        if (o_data !== {old0, old0} || o_phase !== '0) begin
            failures++;
            $display("[TB] FAIL hazard_old_value: got data=%h phase=%0d want data=%h phase=0",
                     o_data, o_phase, {old0, old0});
        end
        for (int r = 0; r < 2; r++) begin
            for (int p = 1; p < OVER_SAMP; p++) begin
                step(1'b0, 1'b1, 1'b0, '0, (r == 0 && p == 1), N_TAPS, 77);
                checks++;
                if (o_data !== exp_data || o_phase !== exp_phase || o_sat !== exp_sat) begin
                    failures++;
                    $display("[TB] FAIL hazard_model: got data=%h phase=%0d sat=%b want data=%h phase=%0d sat=%b",
                             o_data, o_phase, o_sat, exp_data, exp_phase, exp_sat);
                end
            end
            step(1'b0, 1'b1, 1'b0, '0, 1'b0, 0, 0);
            checks++;
            if (o_data !== {new0, new0} || o_phase !== '0) begin
                failures++;
                $display("[TB] FAIL hazard_new_value r=%0d: got data=%h phase=%0d want data=%h phase=0",
                         r, o_data, o_phase, {new0, new0});
            end
        end
    endtask

    task automatic test_saturation();
        int                coefs [4] = '{511, 511, -512, -512};
        logic [N_CH-1:0]   syms  [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
        int                wants [4] = '{1023, -1024, -1024, 1023};
        logic [NB_OUT-1:0] w;
        int                wv;
        for (int s = 0; s < 4; s++) begin
            if (s == 0 || s == 2) load_all(coefs[s]);
            for (int b = 0; b < N_BAUDS; b++) begin
                for (int p = 0; p < OVER_SAMP; p++) begin
                    step(1'b0, 1'b1, (p == 0), syms[s], 1'b0, 0, 0);
                    checks++;
                    if (o_data !== exp_data || o_sat !== exp_sat || o_phase !== exp_phase) begin
                        failures++;
                        $display("[TB] FAIL sat_model s=%0d: got data=%h sat=%b phase=%0d want data=%h sat=%b phase=%0d",
                                 s, o_data, o_sat, o_phase, exp_data, exp_sat, exp_phase);
                    end
                end
            end
            wv = wants[s];
            w  = wv[NB_OUT-1:0];
            checks++;
            if (o_data !== {w, w} || o_sat !== 2'b11) begin
                failures++;
                $display("[TB] FAIL sat_value s=%0d: got data=%h sat=%b want data=%h sat=11",
                         s, o_data, o_sat, {w, w});
            end
        end
    endtask

    task automatic test_random();
        int   r;
        int   cd;
        logic en, vld, we, rs;
        for (int t = 0; t < N_TAPS; t++) begin
            r = $urandom_range(0, 300);
            step(1'b0, 1'b1, 1'b0, '0, 1'b1, t, r - 150);
        end
        for (int i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 9) != 0);
            vld = ($urandom_range(0, 5) == 0);
            we  = ($urandom_range(0, 3) == 0);
            r   = $urandom_range(0, 1023);
            cd  = ($urandom_range(0, 1) == 0) ? (r - 512) : ((r % 201) - 100);
            step(rs, en, vld, 2'($urandom), we, int'($urandom_range(0, 63)), cd);
            checks++;
            if (o_data !== exp_data || o_valid !== exp_valid || o_phase !== exp_phase || o_sat !== exp_sat) begin
                failures++;
                $display("[TB] FAIL random i=%0d: got data=%h valid=%b phase=%0d sat=%b want data=%h valid=%b phase=%0d sat=%b",
                         i, o_data, o_valid, o_phase, o_sat, exp_data, exp_valid, exp_phase, exp_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat_taps();
        test_latency_phase();
        test_enable_gating();
        test_coef_hazard();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
